// File: rtl/in_debounce.sv
// -----------------------------------------------------------------------------
// in_debounce
//
// Debounces a raw asynchronous single-bit level. The input is brought into the
// clk domain through a two-flop synchronizer. The debounced level `out` follows
// the synchronized input only after the two have differed for STABLE_CYCLES
// consecutive clock edges. Any edge where they agree again restarts the count.
//
// Parameters
//   STABLE_CYCLES : consecutive differing cycles needed before out follows
//                   (legal range 1..255, default 4)
//
// Ports
//   clk    : input  - single clock, all state updates on the rising edge
//   areset : input  - asynchronous, active-high reset
//   in     : input  - raw asynchronous level
//   out    : output - debounced, registered level of in
//   rise   : output - one-cycle pulse when out goes 0->1
//   fall   : output - one-cycle pulse when out goes 1->0
//
// Configuration
//   IN_DEBOUNCE_EDGE_PULSE_EN : when defined, rise/fall are registered edge
//                               pulses. When undefined, rise/fall are tied to
//                               0 and no pulse registers exist. The behaviour
//                               of out is the same in both builds.
// -----------------------------------------------------------------------------
module in_debounce #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic areset,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Count value at which the next differing sample commits the new level.
    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    logic       s1;
    logic       s2;
    state_t     state;
    logic [7:0] cnt;
    logic       commit;

    // Two-flop synchronizer. Nothing else looks at `in` directly.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end

    // The new level is accepted on this edge. A single-cycle filter commits
    // straight from STABLE. Otherwise the commit happens in PENDING once the
    // count shows that the previous STABLE_CYCLES-1 samples also differed.
    assign commit = (s2 != out) &&
                    (((state == STABLE) && (STABLE_CYCLES == 1)) ||
                     ((state == PENDING) && (cnt == LAST_CNT)));

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= STABLE;
            cnt   <= 8'd0;
            out   <= 1'b0;
        end else begin
            case (state)
                STABLE: begin
                    if (s2 == out) begin
                        cnt <= 8'd0;
                    end else if (commit) begin
                        out <= s2;
                        cnt <= 8'd0;
                    end else begin
                        state <= PENDING;
                        cnt   <= 8'd1;
                    end
                end
                PENDING: begin
                    if (s2 == out) begin
                        // Glitch: the input went back before the window ended.
                        state <= STABLE;
                        cnt   <= 8'd0;
                    end else if (commit) begin
                        out   <= s2;
                        cnt   <= 8'd0;
                        state <= STABLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

`ifdef IN_DEBOUNCE_EDGE_PULSE_EN
    // The pulses are registered from the same commit condition that updates
    // out. Because of this they appear in the same cycle as the new level and
    // last for one cycle.
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= commit & s2;
            fall_q <= commit & ~s2;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_in_debounce.sv
// -----------------------------------------------------------------------------
// tb_in_debounce
//
// Testbench for in_debounce with STABLE_CYCLES = 4.
// A driver applies each input value at a falling edge. It then steps a
// reference model at the rising edge and queues the expected {out, rise, fall}.
// A monitor pops one expectation after every rising edge and compares it.
// Directed scenarios also measure the commit edge and the pulse counts
// directly.
// -----------------------------------------------------------------------------
module tb_in_debounce;

    localparam int SC = 4;

`ifdef IN_DEBOUNCE_EDGE_PULSE_EN
    localparam bit PULSES = 1'b1;
`else
    localparam bit PULSES = 1'b0;
`endif

    logic clk = 1'b0;
    logic areset;
    logic in;
    logic out;
    logic rise;
    logic fall;

    in_debounce #(.STABLE_CYCLES(SC)) dut (
        .clk    (clk),
        .areset (areset),
        .in     (in),
        .out    (out),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_q[$];

    // Reference model. `out` follows the input as the debouncer sees it
    // (two edges late) once that value has differed from out for SC samples
    // in a row.
    logic hist[$];
    logic m_out;
    int   run;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        m_out = 1'b0;
        run   = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic v);
        logic seen;
        logic r;
        logic f;
        seen = hist.pop_front();
        hist.push_back(v);
        r = 1'b0;
        f = 1'b0;
        if (seen != m_out) begin
            run++;
            if (run == SC) begin
                m_out = seen;
                r     = seen;
                f     = ~seen;
                run   = 0;
            end
        end else begin
            run = 0;
        end
        if (!PULSES) begin
            r = 1'b0;
            f = 1'b0;
        end
        exp_q.push_back({m_out, r, f});
    endtask

    // Called at a falling edge. It drives `in`, crosses one rising edge and
    // returns at the next falling edge.
    task automatic cycle(input logic v);
        in = v;
        @(posedge clk);
        model_step(v);
        @(negedge clk);
    endtask

    // The reset is asserted between clock edges. All outputs must read 0
    // before the next edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        areset = 1'b1;
        #1;
        chk("async_reset_out",  int'(out),  0);
        chk("async_reset_rise", int'(rise), 0);
        chk("async_reset_fall", int'(fall), 0);
        @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        model_reset();
    endtask

    // Hold `v` for 12 cycles. Check that out first reaches v on the 6th
    // edge, that the matching pulse occurs once, and that the opposite
    // pulse never occurs.
    task automatic hold_measure(input logic v, input string name);
        int first;
        int good_pulses;
        int wrong_pulses;
        first        = 0;
        good_pulses  = 0;
        wrong_pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle(v);
            if (out == v && first == 0) first = i;
            if (v ? rise : fall) good_pulses++;
            if (v ? fall : rise) wrong_pulses++;
        end
        chk({name, "_edge"}, first, SC + 2);
        chk({name, "_pulse"}, good_pulses, PULSES ? 1 : 0);
        chk({name, "_wrong_pulse"}, wrong_pulses, 0);
        $display("%s: out followed in at edge %0d, pulses=%0d", name, first, good_pulses);
    endtask

    // Monitor: compares DUT outputs with the queued expectation after each edge.
    initial begin
        forever begin
            logic [2:0] e;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cycle_out_rise_fall", int'({out, rise, fall}), int'(e));
            end
        end
    end

    initial begin
        int changes;
        int pulses;
        int n;
        logic last_out;
        logic v;

        areset = 1'b1;
        in     = 1'b0;
        model_reset();
        #2;
        chk("reset_out",  int'(out),  0);
        chk("reset_rise", int'(rise), 0);
        chk("reset_fall", int'(fall), 0);
        @(negedge clk);
        @(negedge clk);
        areset = 1'b0;
        model_reset();

        // Clean 0->1, then 1->0.
        hold_measure(1'b1, "rise_6th_edge");
        hold_measure(1'b0, "fall_6th_edge");

        // A 3-cycle high blip is shorter than the filter window.
        changes = 0;
        pulses  = 0;
        for (int i = 0; i < 13; i++) begin
            cycle(i < 3 ? 1'b1 : 1'b0);
            if (out != 1'b0) changes++;
            if (rise || fall) pulses++;
        end
        chk("short_blip_out", changes, 0);
        chk("short_blip_pulses", pulses, 0);
        $display("short blip: out high cycles=%0d pulses=%0d", changes, pulses);

        // An input that toggles every cycle never commits.
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(i[0]);
            if (out != 1'b0) changes++;
        end
        chk("toggle_out", changes, 0);
        $display("toggle every cycle: out high cycles=%0d", changes);

        // Asynchronous reset while out=1.
        for (int i = 0; i < 8; i++) cycle(1'b1);
        chk("pre_reset_out_high", int'(out), 1);
        do_reset();
        $display("async reset with out=1 done");

        // Reset during PENDING discards the count. A full window is needed again.
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1);
        do_reset();
        hold_measure(1'b1, "reset_in_pending");

        // Random bursts of held levels with random lengths.
        for (int b = 0; b < 20; b++) begin
            n = 0;
            for (int s = 0; s < 12; s++) begin
                v = 1'($urandom_range(0, 1));
                for (int k = 0; k < int'($urandom_range(1, 7)); k++) begin
                    cycle(v);
                    n++;
                end
            end
            last_out = out;
            $display("burst %0d: %0d cycles, out=%0d", b, n, last_out);
            if (b == 10) begin
                do_reset();
                $display("burst %0d: mid-run reset", b);
            end
        end

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/in_debounce.md
IN_DEBOUNCE -- requirements
Module: in_debounce

Interface
REQ-001 SHALL have parameter: STABLE_CYCLES, default 4, number of consecutive clock cycles the synchronized input must differ from out before out follows it; legal range 1..255.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: areset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in  input  1  raw asynchronous single-bit level.
REQ-005 SHALL have port: out  output  1  debounced, registered level of in.
REQ-006 SHALL have port: rise  output  1  one-cycle pulse on out 0->1.
REQ-007 SHALL have port: fall  output  1  one-cycle pulse on out 1->0.

Function
REQ-008 SHALL pass in through a 2-flop synchronizer (s1<=in, s2<=s1) before any other logic uses it.
REQ-009 SHALL hold an 8-bit counter cnt and a 2-state FSM: STABLE, PENDING.
REQ-010 STABLE: when s2==out, SHALL stay in STABLE with cnt=0; when s2!=out, SHALL go to PENDING with cnt<=1, or commit immediately per REQ-012 if STABLE_CYCLES==1.
REQ-011 PENDING: when s2==out (glitch), SHALL return to STABLE with cnt<=0, leaving out unchanged and no pulse.
REQ-012 PENDING: when s2!=out and cnt==STABLE_CYCLES-1, SHALL commit: out<=s2, cnt<=0, go to STABLE; otherwise cnt<=cnt+1.
REQ-013 Latency: a change on in held steady across the rising edge at which s1 captures it (edge k) SHALL appear on out at edge k+1+STABLE_CYCLES (6th edge for default 4).
REQ-014 rise/fall SHALL be registered, asserted in the same cycle out takes its new value, and deasserted the following cycle.
REQ-015 rise and fall SHALL never be asserted simultaneously, and never without an out transition.
REQ-016 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-017 in toggling every cycle SHALL never change out when STABLE_CYCLES>=2.

Reset
REQ-018 areset high SHALL immediately, without waiting for clk, force s1=0, s2=0, out=0, rise=0, fall=0, cnt=0, state=STABLE.
REQ-019 areset asserted in PENDING SHALL discard the count; after release, a full STABLE_CYCLES+2 edges SHALL be required for any change on out.
REQ-020 On the first rising edge after areset deasserts, the block SHALL operate normally, with no reset-release pulse on rise or fall.

Configuration
REQ-021 Macro IN_DEBOUNCE_EDGE_PULSE_EN defined: rise/fall SHALL behave per REQ-014..015.
REQ-022 Macro IN_DEBOUNCE_EDGE_PULSE_EN undefined: rise/fall ports SHALL remain, tied constant 0, with no pulse registers; out behaviour SHALL be identical.

Verification (STABLE_CYCLES=4, macro defined unless stated)
REQ-023 areset pulsed mid-cycle with out=1 -> out/rise/fall read 0 before the next clk edge.
REQ-024 in 0->1 held -> out=1 exactly at the 6th rising edge, rise=1 that cycle only, fall=0 throughout.
REQ-025 in high for 3 cycles, then low -> out stays 0, rise/fall never asserted.
REQ-026 From out=1, in 1->0 held -> out=0 at the 6th edge, fall=1 for one cycle.
REQ-027 areset asserted 2 cycles into PENDING, released, in still high -> out rises at the 6th edge after release, not earlier.
REQ-028 Macro undefined, repeat the REQ-024 stimulus -> out timing unchanged, rise/fall constant 0.
